// File: rtl/rr_write_arbiter.sv
// rtl/rr_write_arbiter.sv - merges NUM_WRITERS busy-line Writers onto one FIFO write port
// ARB_ROUND_ROBIN_EN selects round-robin search from the last-served Writer; undefined gives fixed lowest-index priority.
module rr_write_arbiter #(
    parameter int NUM_WRITERS = 2,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [NUM_WRITERS*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_WRITERS-1:0]            i_req,
    input  logic                              i_fifo_full,
    output logic [NUM_WRITERS-1:0]            o_busy,
    output logic                              o_we,
    output logic [DATA_WIDTH-1:0]             o_data
);
    localparam int IDX_W = $clog2(NUM_WRITERS);

    logic                   grant_valid;
    logic [IDX_W-1:0]       grant_idx;
    logic [DATA_WIDTH-1:0]  words [NUM_WRITERS];
    logic                   xfer;
    logic                   rearb;
    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic [NUM_WRITERS-1:0] busy_d;

    for (genvar k = 0; k < NUM_WRITERS; k++) begin : g_unpack
        assign words[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign xfer   = grant_valid & i_req[grant_idx] & ~i_fifo_full;
    assign rearb  = ~grant_valid | xfer | ~i_req[grant_idx];
    assign o_we   = xfer;
    assign o_data = grant_valid ? words[grant_idx] : '0;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_ptr;
    logic [IDX_W-1:0] search_base;
    logic [IDX_W-1:0] cand;

    // A Writer served on this edge becomes the new base, so it is visited last.
    assign search_base = xfer ? grant_idx : last_ptr;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NUM_WRITERS; i++) begin
            cand = IDX_W'((int'(search_base) + i) % NUM_WRITERS);
            if (!pick_found && i_req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            last_ptr <= IDX_W'(NUM_WRITERS - 1);
        end else if (xfer) begin
            last_ptr <= grant_idx;
        end
    end
`else
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = NUM_WRITERS - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        busy_d = '1;
        if (pick_found) begin
            busy_d[pick_idx] = 1'b0;
        end
    end

    // Grant and busy lines only move on re-arbitration; back-pressure holds them.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            o_busy      <= '1;
        end else if (rearb) begin
            grant_valid <= pick_found;
            grant_idx   <= pick_idx;
            o_busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_rr_write_arbiter.sv
// tb/tb_rr_write_arbiter.sv - scoreboard bench for rr_write_arbiter with four Writers
module tb_rr_write_arbiter;
    localparam int NW = 4;
    localparam int DW = 8;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic [NW*DW-1:0] i_data;
    logic [NW-1:0]    i_req;
    logic             i_fifo_full;
    logic [NW-1:0]    o_busy;
    logic             o_we;
    logic [DW-1:0]    o_data;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_w;
    logic [DW-1:0] wd [NW] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};

    rr_write_arbiter #(.NUM_WRITERS(NW), .DATA_WIDTH(DW)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_data      (i_data),
        .i_req       (i_req),
        .i_fifo_full (i_fifo_full),
        .o_busy      (o_busy),
        .o_we        (o_we),
        .o_data      (o_data)
    );

    always #5 i_clk = ~i_clk;

    // Every FIFO write must match the next queued expectation.
    always @(negedge i_clk) begin
        if (o_we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write o_data=%h required no write", o_data);
            end else begin
                exp_w = sb.pop_front();
                if (o_data !== exp_w) begin
                    errors++;
                    $display("FAIL sb_write_data o_data=%h required %h", o_data, exp_w);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge i_clk); #1;
        i_reset     = 1'b1;
        i_req       = '0;
        i_fifo_full = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_reset     = 1'b1;
        i_fifo_full = 1'b0;
        i_req       = 4'b0011;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_busy !== 4'b1111) begin
            errors++;
            $display("FAIL reset_busy o_busy=%b required 1111", o_busy);
        end
        checks++;
        if (o_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_we o_we=%b required 0", o_we);
        end
        checks++;
        if (o_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data o_data=%h required 00", o_data);
        end
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        sb.push_back(wd[0]);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        checks++;
        if (o_busy !== 4'b1110 || o_we !== 1'b1 || o_data !== wd[0]) begin
            errors++;
            $display("FAIL first_grant busy=%b we=%b data=%h required 1110 1 %h", o_busy, o_we, o_data, wd[0]);
        end
        @(posedge i_clk); #1;
        i_req = '0;
    endtask

    task automatic test_alternation();
        int order[6];
        logic [NW-1:0] eb;
`ifdef ARB_ROUND_ROBIN_EN
        order = '{0, 1, 0, 1, 0, 1};
`else
        order = '{0, 0, 0, 0, 0, 0};
`endif
        do_reset();
        @(posedge i_clk); #1;
        i_req = 4'b0011;
        foreach (order[k]) sb.push_back(wd[order[k]]);
        for (int k = 0; k < 6; k++) begin
            @(posedge i_clk); #1;
            @(negedge i_clk);
            eb = ~(4'b0001 << order[k]);
            checks++;
            if (o_we !== 1'b1 || o_busy !== eb) begin
                errors++;
                $display("FAIL alternation_%0d we=%b busy=%b required 1 %b", k, o_we, o_busy, eb);
            end
        end
        @(posedge i_clk); #1;
        i_req = '0;
        @(negedge i_clk);
        checks++;
        if (o_we !== 1'b0) begin
            errors++;
            $display("FAIL alternation_stop o_we=%b required 0", o_we);
        end
    endtask

    task automatic test_sole_requester();
        do_reset();
        @(posedge i_clk); #1;
        i_req = 4'b0100;
        repeat (4) sb.push_back(wd[2]);
        for (int k = 0; k < 4; k++) begin
            @(posedge i_clk); #1;
            @(negedge i_clk);
            checks++;
            if (o_we !== 1'b1 || o_busy !== 4'b1011) begin
                errors++;
                $display("FAIL sole_%0d we=%b busy=%b required 1 1011", k, o_we, o_busy);
            end
        end
        @(posedge i_clk); #1;
        i_req = '0;
    endtask

    task automatic test_back_pressure();
        int nxt;
        logic [NW-1:0] eb;
`ifdef ARB_ROUND_ROBIN_EN
        nxt = 3;
`else
        nxt = 1;
`endif
        do_reset();
        @(posedge i_clk); #1;
        i_fifo_full = 1'b1;
        i_req       = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk); #1;
            @(negedge i_clk);
            checks++;
            if (o_we !== 1'b0 || o_busy !== 4'b1101 || o_data !== wd[1]) begin
                errors++;
                $display("FAIL full_hold_%0d we=%b busy=%b data=%h required 0 1101 %h", k, o_we, o_busy, o_data, wd[1]);
            end
        end
        @(posedge i_clk); #1;
        i_fifo_full = 1'b0;
        sb.push_back(wd[1]);
        sb.push_back(wd[nxt]);
        @(negedge i_clk);
        checks++;
        if (o_we !== 1'b1 || o_busy !== 4'b1101) begin
            errors++;
            $display("FAIL full_release we=%b busy=%b required 1 1101", o_we, o_busy);
        end
        @(posedge i_clk); #1;
        @(negedge i_clk);
        eb = ~(4'b0001 << nxt);
        checks++;
        if (o_we !== 1'b1 || o_busy !== eb) begin
            errors++;
            $display("FAIL full_next we=%b busy=%b required 1 %b", o_we, o_busy, eb);
        end
        @(posedge i_clk); #1;
        i_req = '0;
    endtask

    task automatic test_wrap();
        int order[5];
        logic [NW-1:0] eb;
`ifdef ARB_ROUND_ROBIN_EN
        order = '{0, 1, 2, 3, 0};
`else
        order = '{0, 0, 0, 0, 0};
`endif
        do_reset();
        @(posedge i_clk); #1;
        i_req = 4'b1111;
        foreach (order[k]) sb.push_back(wd[order[k]]);
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk); #1;
            @(negedge i_clk);
            eb = ~(4'b0001 << order[k]);
            checks++;
            if (o_we !== 1'b1 || o_busy !== eb) begin
                errors++;
                $display("FAIL wrap_%0d we=%b busy=%b required 1 %b", k, o_we, o_busy, eb);
            end
        end
        @(posedge i_clk); #1;
        i_req = '0;
    endtask

    task automatic test_reset_mid();
        int second;
`ifdef ARB_ROUND_ROBIN_EN
        second = 1;
`else
        second = 0;
`endif
        do_reset();
        @(posedge i_clk); #1;
        i_req = 4'b1111;
        sb.push_back(wd[0]);
        sb.push_back(wd[second]);
        repeat (2) begin
            @(posedge i_clk); #1;
            @(negedge i_clk);
        end
        @(posedge i_clk); #1;
        checks++;
        if (o_we !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_we o_we=%b required 1", o_we);
        end
        i_reset = 1'b1;
        #1;
        checks++;
        if (o_we !== 1'b0 || o_busy !== 4'b1111 || o_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_async we=%b busy=%b data=%h required 0 1111 00", o_we, o_busy, o_data);
        end
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
        sb.push_back(wd[0]);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        checks++;
        if (o_we !== 1'b1 || o_busy !== 4'b1110) begin
            errors++;
            $display("FAIL mid_restart we=%b busy=%b required 1 1110", o_we, o_busy);
        end
        @(posedge i_clk); #1;
        i_req = '0;
    endtask

    initial begin
        i_data = {wd[3], wd[2], wd[1], wd[0]};
        test_reset();
        test_alternation();
        test_sole_requester();
        test_back_pressure();
        test_wrap();
        test_reset_mid();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain pending=%0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
